// File: rtl/wb_hex_word_tx.sv
// wb_hex_word_tx: buffered hex-word printer.
// Words enter a 2^FIFO_LGDEPTH-entry FIFO on i_stb && o_ready. Each word is printed as an
// optional "0x" prefix, W/4 hex digits MSB-first, and an optional line ending. The output
// is a byte-wide char port for wb_uart_tx (o_tx_stb -> i_wr, o_tx_data -> i_data,
// i_tx_busy <- o_busy).
// Optional feature macro: WB_HEX_TX_DROP_CNT_EN (counts words offered while full on o_drops).
module wb_hex_word_tx #(
  parameter int W            = 32,
  parameter int FIFO_LGDEPTH = 2,
  parameter int PREFIX_EN    = 1,
  parameter int EOL_MODE     = 2,
  parameter int UPPERCASE    = 0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic [W-1:0]  i_data,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_tx_stb,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy,
  output logic [15:0]   o_drops
);

  localparam int unsigned DEPTH  = 1 << FIFO_LGDEPTH;
  localparam int unsigned DIGITS = W / 4;
  localparam int unsigned DCW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DCW-1:0]        LAST_DIG   = DCW'(DIGITS - 1);
  localparam logic [FIFO_LGDEPTH:0] FULL_COUNT = (FIFO_LGDEPTH + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_PX   = 3'd2;
  localparam logic [2:0] S_DIG  = 3'd3;
  localparam logic [2:0] S_CR   = 3'd4;
  localparam logic [2:0] S_LF   = 3'd5;

  // Optional stages are skipped by choosing the entry/exit states at elaboration time.
  localparam logic [2:0] S_FIRST     = (PREFIX_EN != 0) ? S_P0 : S_DIG;
  localparam logic [2:0] S_AFTER_DIG = (EOL_MODE == 2) ? S_CR :
                                       (EOL_MODE == 1) ? S_LF : S_IDLE;

  logic [W-1:0]            mem [DEPTH];
  logic [FIFO_LGDEPTH-1:0] wr_ptr;
  logic [FIFO_LGDEPTH-1:0] rd_ptr;
  logic [FIFO_LGDEPTH:0]   count;

  logic [2:0]              state;
  logic [W-1:0]            sreg;
  logic [DCW-1:0]          dig_cnt;

  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    consume;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else if (UPPERCASE != 0)
      return 8'h37 + {4'h0, n};
    else
      return 8'h57 + {4'h0, n};
  endfunction

  // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
  assign full     = (count == FULL_COUNT);
  assign o_ready  = !full;
  assign push     = i_stb && !full;
  assign pop      = (state == S_IDLE) && (count != '0);
  assign o_tx_stb = (state != S_IDLE);
  assign consume  = o_tx_stb && !i_tx_busy;
  assign o_busy   = (count != '0) || (state != S_IDLE);

  // FIFO storage write port.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= i_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Character sequencer: advances one char per consume, returns to IDLE after the last char.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      sreg    <= '0;
      dig_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state   <= S_FIRST;
            sreg    <= mem[rd_ptr];
            dig_cnt <= '0;
          end
        end
        S_P0: if (consume) state <= S_PX;
        S_PX: begin
          if (consume) begin
            state   <= S_DIG;
            dig_cnt <= '0;
          end
        end
        S_DIG: begin
          if (consume) begin
            sreg <= sreg << 4;
            if (dig_cnt == LAST_DIG)
              state <= S_AFTER_DIG;
            else
              dig_cnt <= dig_cnt + 1'b1;
          end
        end
        S_CR: if (consume) state <= S_LF;
        S_LF: if (consume) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Char decode from registered state/sreg: stable while the UART stalls, 00 when idle.
  always_comb begin
    o_tx_data = 8'h00;
    case (state)
      S_P0:    o_tx_data = 8'h30;
      S_PX:    o_tx_data = 8'h78;
      S_DIG:   o_tx_data = hex_char(sreg[W-1 -: 4]);
      S_CR:    o_tx_data = 8'h0D;
      S_LF:    o_tx_data = 8'h0A;
      default: o_tx_data = 8'h00;
    endcase
  end

`ifdef WB_HEX_TX_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of words offered while the FIFO is full.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      drop_cnt <= '0;
    else if (i_stb && full && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 1'b1;
  end

  assign o_drops = drop_cnt;
`else
  assign o_drops = '0;
`endif

endmodule

// File: tb/tb_wb_hex_word_tx.sv
// tb_wb_hex_word_tx: three configurations of wb_hex_word_tx (defaults; W=16 no prefix "\n";
// uppercase) each driven by a small UART model that records consumed chars into a string.
// Expected output text is built with $sformatf from the words pushed.
module tb_wb_hex_word_tx;

  logic              clk = 1'b0;
  logic              rst;
  logic              stb   [3];
  logic              ubusy [3];
  logic              hold  [3];
  logic [31:0]       d0;
  logic [15:0]       d1;
  logic [31:0]       d2;
  logic [2:0]        ready;
  logic [2:0]        busy;
  logic [2:0]        tx_stb;
  logic [2:0][7:0]   tx_data;
  logic [2:0][15:0]  drops;

  int                gap [3];
  string             got [3];
  logic [31:0]       bw   [8];
  logic              brdy [8];

  int tests = 0;
  int fails = 0;

`ifdef WB_HEX_TX_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd1;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  always #5 clk = ~clk;

  wb_hex_word_tx u0 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb[0]), .i_data(d0),
    .o_ready(ready[0]), .o_busy(busy[0]), .o_tx_stb(tx_stb[0]), .o_tx_data(tx_data[0]),
    .i_tx_busy(ubusy[0] | hold[0]), .o_drops(drops[0])
  );

  wb_hex_word_tx #(.W(16), .PREFIX_EN(0), .EOL_MODE(1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb[1]), .i_data(d1),
    .o_ready(ready[1]), .o_busy(busy[1]), .o_tx_stb(tx_stb[1]), .o_tx_data(tx_data[1]),
    .i_tx_busy(ubusy[1] | hold[1]), .o_drops(drops[1])
  );

  wb_hex_word_tx #(.UPPERCASE(1)) u2 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb[2]), .i_data(d2),
    .o_ready(ready[2]), .o_busy(busy[2]), .o_tx_stb(tx_stb[2]), .o_tx_data(tx_data[2]),
    .i_tx_busy(ubusy[2] | hold[2]), .o_drops(drops[2])
  );

  // Expected text of one word for each instance's configuration.
  function automatic string fmt_word(input int k, input logic [31:0] w);
    string h;
    case (k)
      1: return $sformatf("%h\n", w[15:0]);
      2: begin
        h = $sformatf("%h", w);
        return {"0x", h.toupper(), "\r\n"};
      end
      default: return $sformatf("0x%h\r\n", w);
    endcase
  endfunction

  // Make CR/LF visible on a single report line.
  function automatic string esc(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "\\r"};
      else if (s[i] == 8'h0A) r = {r, "\\n"};
      else                    r = {r, s.substr(i, i)};
    end
    return r;
  endfunction

  // UART: consumes when strobe and not busy, then stays busy for gap[k] cycles.
  task automatic uart_model(input int k);
    forever begin
      @(negedge clk);
      if (tx_stb[k] && !(ubusy[k] || hold[k])) begin
        got[k] = $sformatf("%s%c", got[k], tx_data[k]);
        @(posedge clk);
        #1 ubusy[k] = 1'b1;
        repeat (gap[k]) @(posedge clk);
        #1 ubusy[k] = 1'b0;
      end
    end
  endtask

  // Back-to-back pushes of bw[0..n-1]; brdy[i] records o_ready for each offer.
  task automatic burst(input int k, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      stb[k] = 1'b1;
      case (k)
        1:       d1 = bw[i][15:0];
        2:       d2 = bw[i];
        default: d0 = bw[i];
      endcase
      brdy[i] = ready[k];
      @(negedge clk);
    end
    stb[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    do begin
      @(posedge clk);
      #2 n++;
    end while ((busy[k] || ubusy[k]) && n < 3000);
    tests++;
    if (busy[k] || ubusy[k]) begin
      fails++;
      $display("FAIL idle_timeout[%0d]: busy=%b uart_busy=%b required 0 within 3000 cycles",
               k, busy[k], ubusy[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++; if (tx_stb[k] !== 1'b0) begin fails++; $display("FAIL reset_tx_stb[%0d]: got %b want 0", k, tx_stb[k]); end
      tests++; if (tx_data[k] !== 8'h00) begin fails++; $display("FAIL reset_tx_data[%0d]: got %h want 00", k, tx_data[k]); end
      tests++; if (ready[k] !== 1'b1) begin fails++; $display("FAIL reset_ready[%0d]: got %b want 1", k, ready[k]); end
      tests++; if (busy[k] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
      tests++; if (drops[k] !== 16'h0000) begin fails++; $display("FAIL reset_drops[%0d]: got %h want 0000", k, drops[k]); end
    end
  endtask

  task automatic test_deadbeef();
    int n = 0;
    gap[0] = 3;
    got[0] = "";
    bw[0] = 32'hDEADBEEF;
    burst(0, 1);
    tests++; if (brdy[0] !== 1'b1) begin fails++; $display("FAIL deadbeef_ready: got %b want 1", brdy[0]); end
    while (got[0].len() < 12 && n < 500) begin
      @(posedge clk);
      #2 n++;
    end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL deadbeef_busy_after_lf: got %b want 0", busy[0]); end
    wait_idle(0);
    tests++;
    if (got[0] != "0xdeadbeef\r\n") begin
      fails++; $display("FAIL deadbeef_text: got \"%s\" want \"%s\"", esc(got[0]), esc("0xdeadbeef\r\n"));
    end
  endtask

  task automatic test_latency();
    gap[1] = 1;
    got[1] = "";
    @(negedge clk);
    stb[1] = 1'b1;
    d1 = 16'h00A5;
    @(negedge clk);
    stb[1] = 1'b0;
    tests++; if (tx_stb[1] !== 1'b0) begin fails++; $display("FAIL latency_n1: tx_stb got %b want 0", tx_stb[1]); end
    @(negedge clk);
    tests++; if (tx_stb[1] !== 1'b1) begin fails++; $display("FAIL latency_n2: tx_stb got %b want 1", tx_stb[1]); end
    tests++; if (tx_data[1] !== 8'h30) begin fails++; $display("FAIL latency_first_char: got %h want 30", tx_data[1]); end
    wait_idle(1);
    tests++;
    if (got[1] != "00a5\n") begin
      fails++; $display("FAIL w16_text: got \"%s\" want \"%s\"", esc(got[1]), esc("00a5\n"));
    end
  endtask

  task automatic test_uppercase();
    gap[2] = 2;
    got[2] = "";
    bw[0] = 32'hABCDEF01;
    burst(2, 1);
    wait_idle(2);
    tests++;
    if (got[2] != "0xABCDEF01\r\n") begin
      fails++; $display("FAIL upper_text: got \"%s\" want \"%s\"", esc(got[2]), esc("0xABCDEF01\r\n"));
    end
  endtask

  task automatic test_hold();
    int n = 0;
    int bad = 0;
    got[0] = "";
    @(posedge clk);
    #1 hold[0] = 1'b1;
    bw[0] = 32'h12345678;
    burst(0, 1);
    while (!tx_stb[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++; if (tx_data[0] !== 8'h30) begin fails++; $display("FAIL hold_first_char: got %h want 30", tx_data[0]); end
    gap[0] = 25;
    @(posedge clk);
    #1 hold[0] = 1'b0;
    @(posedge clk);
    repeat (20) begin
      @(negedge clk);
      if (tx_stb[0] !== 1'b1 || tx_data[0] !== 8'h78) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_x_stable: %0d of 20 cycles not stb=1/data=78", bad); end
    gap[0] = 3;
    wait_idle(0);
    tests++;
    if (got[0] != "0x12345678\r\n") begin
      fails++; $display("FAIL hold_text: got \"%s\" want \"%s\"", esc(got[0]), esc("0x12345678\r\n"));
    end
  endtask

  task automatic test_drops();
    string exp = "";
    logic  exp_r;
    got[0] = "";
    gap[0] = 2;
    @(posedge clk);
    #1 hold[0] = 1'b1;
    for (int i = 0; i < 6; i++) bw[i] = 32'(i + 1);
    burst(0, 6);
    for (int i = 0; i < 6; i++) begin
      exp_r = (i < 5);
      tests++;
      if (brdy[i] !== exp_r) begin fails++; $display("FAIL drops_ready[%0d]: got %b want %b", i, brdy[i], exp_r); end
    end
    tests++; if (ready[0] !== 1'b0) begin fails++; $display("FAIL drops_full: ready got %b want 0", ready[0]); end
    tests++; if (drops[0] !== EXP_DROPS) begin fails++; $display("FAIL drops_count: got %0d want %0d", drops[0], EXP_DROPS); end
    @(posedge clk);
    #1 hold[0] = 1'b0;
    wait_idle(0);
    for (int i = 0; i < 5; i++) exp = {exp, fmt_word(0, bw[i])};
    tests++;
    if (got[0] != exp) begin
      fails++; $display("FAIL drops_text: got \"%s\" want \"%s\"", esc(got[0]), esc(exp));
    end
  endtask

  task automatic test_random();
    string exp;
    int    n;
    for (int k = 0; k < 3; k++) begin
      repeat (5) begin
        got[k] = "";
        exp = "";
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) bw[i] = $urandom;
        gap[k] = $urandom_range(1, 4);
        burst(k, n);
        for (int i = 0; i < n; i++) begin
          tests++;
          if (brdy[i] !== 1'b1) begin fails++; $display("FAIL rand_ready[%0d]: offer %0d got %b want 1", k, i, brdy[i]); end
          exp = {exp, fmt_word(k, bw[i])};
        end
        repeat ($urandom_range(0, 30)) @(posedge clk);
        wait_idle(k);
        tests++;
        if (got[k] != exp) begin
          fails++; $display("FAIL rand_text[%0d]: got \"%s\" want \"%s\"", k, esc(got[k]), esc(exp));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    gap[0] = 3;
    got[0] = "";
    bw[0] = 32'hDEADBEEF;
    bw[1] = 32'h11111111;
    bw[2] = 32'h22222222;
    burst(0, 3);
    while (got[0].len() < 4 && n < 200) begin
      @(posedge clk);
      #2 n++;
    end
    tests++;
    if (got[0] != "0xde") begin fails++; $display("FAIL midreset_prefix: got \"%s\" want \"0xde\"", esc(got[0])); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (tx_stb[0] !== 1'b0) begin fails++; $display("FAIL midreset_tx_stb: got %b want 0", tx_stb[0]); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy[0]); end
    tests++; if (ready[0] !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", ready[0]); end
    tests++; if (drops[0] !== 16'h0000) begin fails++; $display("FAIL midreset_drops: got %h want 0000", drops[0]); end
    got[0] = "";
    bw[0] = 32'h00000001;
    burst(0, 1);
    wait_idle(0);
    tests++;
    if (got[0] != "0x00000001\r\n") begin
      fails++; $display("FAIL midreset_text: got \"%s\" want \"%s\"", esc(got[0]), esc("0x00000001\r\n"));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      stb[k]   = 1'b0;
      ubusy[k] = 1'b0;
      hold[k]  = 1'b0;
      gap[k]   = 1;
      got[k]   = "";
    end
    d0  = '0;
    d1  = '0;
    d2  = '0;
    rst = 1'b1;
    fork
      uart_model(0);
      uart_model(1);
      uart_model(2);
    join_none
    test_reset();
    test_deadbeef();
    test_latency();
    test_uppercase();
    test_hold();
    test_drops();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
